// File: rtl/mont_mult_ctrl_pkg.sv
// Shared definitions for the Montgomery multiplication sequencer:
// state encoding, operand-select codes and the default operand width.
package mont_mult_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRECOMP = 3'd1,
    ST_LOOP    = 3'd2,
    ST_FINAL   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Operand select codes, indexed by {ai, qi}
  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_M    = 2'b01;
  localparam logic [1:0] SEL_B    = 2'b10;
  localparam logic [1:0] SEL_MB   = 2'b11;

endpackage

// File: rtl/mont_mult_ctrl_step.sv
// One radix-2 Montgomery iteration: derive qi, pick 0/B/M/M+B from {ai,qi},
// add to the running remainder and halve. Purely combinational.
module mont_step
  import mont_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   r_in,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] m_in,
  input  logic [WIDTH:0]   mb_in,
  output logic [WIDTH:0]   r_out
);

  logic             q_bit;
  logic [1:0]       sel;
  logic [WIDTH:0]   addend;
  logic [WIDTH+1:0] sum;

  // Select the addend and form (R + sel) >> 1 with a full WIDTH+2-bit sum.
  // qi is chosen so the sum is always even, so the dropped LSB is zero.
  always_comb begin
    q_bit  = r_in[0] ^ (a_bit & b_in[0]);
    sel    = {a_bit, q_bit};
    addend = '0;
    case (sel)
      SEL_MB:   addend = mb_in;
      SEL_B:    addend = {1'b0, b_in};
      SEL_M:    addend = {1'b0, m_in};
      default:  addend = '0;
    endcase
    sum   = {1'b0, r_in} + {1'b0, addend};
    r_out = (WIDTH+1)'(sum >> 1);
  end

endmodule

// File: rtl/mont_mult_ctrl.sv
// Sequencer for one bit-serial Montgomery multiplication R = A*B*2^-WIDTH mod M.
// Handshake: start is a request sampled only in IDLE; busy covers the
// operation; done is a one-cycle pulse during which result/err are valid
// (and they stay held until the next accepted start).
module mont_mult_ctrl
  import mont_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] m_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       state_dbg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH:0]   mb_q, mb_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH:0]   r_step;

  mont_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (r_q),
    .a_bit (a_q[cnt_q]),
    .b_in  (b_q),
    .m_in  (m_q),
    .mb_in (mb_q),
    .r_out (r_step)
  );

  // Next-state and datapath control for the whole operation.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    mb_d     = mb_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = a_in;
          b_d      = b_in;
          m_d      = m_in;
          mb_d     = '0;
          r_d      = '0;
          cnt_d    = '0;
          result_d = '0;
          err_d    = 1'b0;
          // An even modulus skips the arithmetic but still passes through
          // FINAL so done lands one edge later, with busy never raised.
          if (!m_in[0]) begin
            state_d = ST_FINAL;
          end else begin
            busy_d  = 1'b1;
            state_d = ST_PRECOMP;
          end
        end
      end
      ST_PRECOMP: begin
        mb_d    = {1'b0, m_q} + {1'b0, b_q};
        state_d = ST_LOOP;
      end
      ST_LOOP: begin
        r_d   = r_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        if (!m_q[0]) begin
          err_d    = 1'b1;
          result_d = '0;
        end else if (r_q >= {1'b0, m_q}) begin
          result_d = WIDTH'(r_q - {1'b0, m_q});
        end else begin
          result_d = WIDTH'(r_q);
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      mb_q     <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      mb_q     <= mb_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mont_mult_ctrl.sv
// Directed and randomised bench for mont_mult_ctrl at WIDTH=8 and WIDTH=16.
module tb_mont_mult_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        start8, busy8, done8, err8;
  logic [7:0]  a8, b8, m8, res8;
  logic [2:0]  st8;
  logic        start16, busy16, done16, err16;
  logic [15:0] a16, b16, m16, res16;
  logic [2:0]  st16;

  mont_mult_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8), .m_in(m8),
    .busy(busy8), .done(done8), .err(err8), .result(res8), .state_dbg(st8)
  );

  mont_mult_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a_in(a16), .b_in(b16), .m_in(m16),
    .busy(busy16), .done(done16), .err(err16), .result(res16), .state_dbg(st16)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_lat_q[$];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          fail_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A*B*2^-w mod m via repeated modular halving (m odd)
  function automatic logic [15:0] mont_ref(input longint a, input longint b,
                                           input longint m, input int w);
    longint x;
    x = (a * b) % m;
    for (int i = 0; i < w; i++) x = (x % 2 == 1) ? (x + m) / 2 : x / 2;
    return 16'(x);
  endfunction

  function automatic logic g_done(input int w);
    return (w == 8) ? done8 : done16;
  endfunction
  function automatic logic g_busy(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction
  function automatic logic g_err(input int w);
    return (w == 8) ? err8 : err16;
  endfunction
  function automatic logic [15:0] g_res(input int w);
    return (w == 8) ? {8'h00, res8} : res16;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive start for one edge, push the expected outcome, check busy after edge 1.
  task automatic launch(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] m, input string tag);
    exp_q.push_back(m[0] ? mont_ref(a, b, m, w) : 16'h0);
    exp_err_q.push_back(~m[0]);
    exp_lat_q.push_back(m[0] ? w + 3 : 2);
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; m8 = m[7:0]; start8 = 1'b1;
    end else begin
      a16 = a; b16 = b; m16 = m; start16 = 1'b1;
    end
    step();
    start8  = 1'b0;
    start16 = 1'b0;
    check({tag, "_busy_e1"}, g_busy(w), m[0]);
  endtask

  // Wait (bounded) for done, then pop and compare against the scoreboard.
  task automatic finish(input int w, input int n0, input string tag);
    int   n;
    logic got;
    logic busy_seen;
    logic [15:0] e_res;
    logic        e_err;
    int          e_lat;
    n         = n0;
    got       = g_done(w);
    busy_seen = 1'b0;
    while (!got && n < 60) begin
      step();
      n++;
      got = g_done(w);
      if (!got && g_busy(w)) busy_seen = 1'b1;
    end
    e_res = exp_q.pop_front();
    e_err = exp_err_q.pop_front();
    e_lat = exp_lat_q.pop_front();
    check({tag, "_done_seen"}, got, 1'b1);
    if (got) begin
      check({tag, "_latency"}, n, e_lat);
      check({tag, "_result"}, g_res(w), e_res);
      check({tag, "_err"}, g_err(w), e_err);
      check({tag, "_busy_at_done"}, g_busy(w), 1'b0);
      if (e_err) check({tag, "_err_no_busy"}, busy_seen, 1'b0);
      step();
      check({tag, "_done_pulse"}, g_done(w), 1'b0);
    end
  endtask

  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] m, input string tag);
    launch(w, a, b, m, tag);
    finish(w, 1, tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, prev, ndone, extra;
    logic [15:0] ra, rb, rm;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; m8 = '0;
    start16 = 1'b0; a16 = '0; b16 = '0; m16 = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_err", err8, 1'b0);
    check("rst_result", res8, 8'h00);
    check("rst_state", st8, 3'd0);
    check("rst_result16", res16, 16'h0);
    rst_n = 1'b1;
    step();

    run_op(8, 16'd7, 16'd5, 16'd13, "basic");
    run_op(8, 16'd12, 16'd12, 16'd13, "a12b12");
    run_op(8, 16'd254, 16'd254, 16'd255, "maxw");
    run_op(8, 16'd0, 16'd9, 16'd13, "a_zero");
    run_op(8, 16'd7, 16'd5, 16'd12, "even_m");
    run_op(8, 16'd7, 16'd5, 16'd13, "err_clear");

    // start re-pulsed during LOOP with other operands must be ignored
    launch(8, 16'd7, 16'd5, 16'd13, "repulse");
    step();
    step();
    a8 = 8'd12; b8 = 8'd12; m8 = 8'd15; start8 = 1'b1;
    step();
    start8 = 1'b0;
    finish(8, 4, "repulse");
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done8) extra++;
    end
    check("repulse_no_queued", extra, 0);

    // start held high: back-to-back ops every WIDTH+4 cycles
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mont_ref(12, 12, 13, 8));
      exp_err_q.push_back(1'b0);
      exp_lat_q.push_back(0);
    end
    a8 = 8'd12; b8 = 8'd12; m8 = 8'd13; start8 = 1'b1;
    n = 0; prev = 0; ndone = 0;
    while (ndone < 3 && n < 100) begin
      step();
      n++;
      if (done8) begin
        check($sformatf("held_interval_%0d", ndone), n - prev, (ndone == 0) ? 11 : 12);
        check($sformatf("held_result_%0d", ndone), res8, exp_q.pop_front());
        check($sformatf("held_err_%0d", ndone), err8, exp_err_q.pop_front());
        void'(exp_lat_q.pop_front());
        prev = n;
        ndone++;
        if (ndone == 3) start8 = 1'b0;
      end
    end
    check("held_count", ndone, 3);
    while (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      void'(exp_err_q.pop_front());
      void'(exp_lat_q.pop_front());
    end
    step();
    step();
    check("held_idle", st8, 3'd0);

    // asynchronous reset in the middle of LOOP
    a8 = 8'd7; b8 = 8'd5; m8 = 8'd13; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("pre_rst_busy", busy8, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy8, 1'b0);
    check("arst_done", done8, 1'b0);
    check("arst_result", res8, 8'h00);
    check("arst_state", st8, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done8) extra++;
    end
    check("arst_no_done", extra, 0);
    run_op(8, 16'd7, 16'd5, 16'd13, "post_rst");

    run_op(16, 16'd1234, 16'd5678, 16'd40001, "w16_dir");

    // randomised operations, odd M, A,B < M
    for (int i = 0; i < 1000; i++) begin
      rm = 16'($urandom_range(3, 255)) | 16'h1;
      ra = 16'($urandom_range(0, int'(rm) - 1));
      rb = 16'($urandom_range(0, int'(rm) - 1));
      run_op(8, ra, rb, rm, "rand8");
    end
    for (int i = 0; i < 1000; i++) begin
      rm = 16'($urandom_range(3, 65535)) | 16'h1;
      ra = 16'($urandom_range(0, int'(rm) - 1));
      rb = 16'($urandom_range(0, int'(rm) - 1));
      run_op(16, ra, rb, rm, "rand16");
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
